// File: rtl/boolean_function_sweep_checker_pkg.sv
// Shared types and constants for the boolean function sweep checker.
package boolean_function_sweep_checker_pkg;

  localparam int NUM_VECTORS = 8;
  localparam int VEC_W       = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bump the mismatch counter by one when the current sample missed.
  function automatic logic [3:0] bump_err(input logic [3:0] cnt, input logic miss);
    return cnt + {3'b000, miss};
  endfunction

endpackage

// File: rtl/boolean_function_hold_timer.sv
// Counts cycles a vector has been held; flags the cycle on which D is sampled.
module boolean_function_hold_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;

  // Expire only while counting, so an idle timer never triggers a sample.
  assign expire = enable && (cnt_r == LAST);

  // Hold counter: cleared on a new sweep, wraps to zero after each sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (enable) begin
      if (cnt_r == LAST) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/boolean_function_sweep_checker.sv
// Drives A/B/C through all 8 input vectors, samples D after each hold
// period and compares it against the expected truth table.
module boolean_function_sweep_checker
  import boolean_function_sweep_checker_pkg::*;
#(
  parameter int                     HOLD_CYCLES = 4,
  parameter logic [NUM_VECTORS-1:0] EXPECTED    = 8'hE8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  input  logic       d_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] first_fail_idx,
  output logic       first_fail_valid
);

  localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(NUM_VECTORS - 1);

  state_e           state_r, state_s;
  logic [VEC_W-1:0] idx_r, idx_s;
  logic [VEC_W-1:0] vec_r, vec_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             pass_r, pass_s;
  logic [3:0]       err_r, err_s;
  logic [2:0]       ffi_r, ffi_s;
  logic             ffv_r, ffv_s;
  logic             clear_s;
  logic             expire_s;
  logic             mismatch_s;

  boolean_function_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear_s),
    .enable(state_r == DRIVE),
    .expire(expire_s)
  );

  // D is compared against the truth-table bit for the vector currently driven.
  assign mismatch_s = (d_in != EXPECTED[idx_r]);

  // Next-state and next-result logic; every register holds unless changed.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    vec_s   = vec_r;
    busy_s  = busy_r;
    done_s  = done_r;
    pass_s  = pass_r;
    err_s   = err_r;
    ffi_s   = ffi_r;
    ffv_s   = ffv_r;
    clear_s = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_s = DRIVE;
          idx_s   = '0;
          vec_s   = '0;
          busy_s  = 1'b1;
          done_s  = 1'b0;
          pass_s  = 1'b0;
          err_s   = 4'd0;
          ffi_s   = 3'd0;
          ffv_s   = 1'b0;
          clear_s = 1'b1;
        end else begin
          clear_s = 1'b0;
        end
      end
      DRIVE: begin
        if (expire_s) begin
          err_s = bump_err(err_r, mismatch_s);
          if (mismatch_s && !ffv_r) begin
            ffi_s = idx_r;
            ffv_s = 1'b1;
          end else begin
            ffi_s = ffi_r;
            ffv_s = ffv_r;
          end
          if (idx_r == LAST_IDX) begin
            state_s = DONE;
            vec_s   = '0;
            busy_s  = 1'b0;
            done_s  = 1'b1;
            pass_s  = (err_s == 4'd0);
          end else begin
            idx_s = idx_r + VEC_W'(1);
            vec_s = idx_r + VEC_W'(1);
          end
        end else begin
          state_s = DRIVE;
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = '0;
        vec_s   = '0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        pass_s  = 1'b0;
        err_s   = 4'd0;
        ffi_s   = 3'd0;
        ffv_s   = 1'b0;
      end
    endcase
  end

  // State and result registers; reset returns to IDLE with all outputs low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      idx_r   <= '0;
      vec_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
      err_r   <= 4'd0;
      ffi_r   <= 3'd0;
      ffv_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      vec_r   <= vec_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      pass_r  <= pass_s;
      err_r   <= err_s;
      ffi_r   <= ffi_s;
      ffv_r   <= ffv_s;
    end
  end

  assign a_out            = vec_r[2];
  assign b_out            = vec_r[1];
  assign c_out            = vec_r[0];
  assign busy             = busy_r;
  assign done             = done_r;
  assign pass             = pass_r;
  assign err_count        = err_r;
  assign first_fail_idx   = ffi_r;
  assign first_fail_valid = ffv_r;

endmodule

// File: tb/tb_boolean_function_sweep_checker.sv
// Self-checking bench: table-driven and random truth tables checked against
// a truth-table comparison model, plus hand-written start/reset sequences.
module tb_boolean_function_sweep_checker;

  localparam int H = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, start1;
  logic [7:0] func_tt, func_tt1;
  logic [7:0] exp_tt;

  logic       a_out, b_out, c_out, d_in, busy, done, pass, ffv;
  logic [3:0] err_count;
  logic [2:0] ffi;
  logic       a1, b1, c1, d1, busy1, done1, pass1, ffv1;
  logic [3:0] err1;
  logic [2:0] ffi1;

  // Function blocks under test are truth-table lookups on the driven vector.
  assign d_in = func_tt[{a_out, b_out, c_out}];
  assign d1   = func_tt1[{a1, b1, c1}];

  boolean_function_sweep_checker #(.HOLD_CYCLES(H), .EXPECTED(8'hE8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_out(a_out), .b_out(b_out), .c_out(c_out), .d_in(d_in),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_idx(ffi), .first_fail_valid(ffv)
  );

  boolean_function_sweep_checker #(.HOLD_CYCLES(1), .EXPECTED(8'hE8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .a_out(a1), .b_out(b1), .c_out(c1), .d_in(d1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_idx(ffi1), .first_fail_valid(ffv1)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks_total++;
    if (actual == expected) checks_passed++;
    else $display("FAIL %s: got %0d, want %0d", name, actual, expected);
  endtask

  // Reference: count truth-table bits that differ from the expected table,
  // and report the lowest differing vector index.
  task automatic model(input logic [7:0] tt, output int err, output int fi,
                       output int fv, output int ps);
    err = 0; fi = 0; fv = 0;
    for (int i = 0; i < 8; i++) begin
      if (tt[i] != exp_tt[i]) begin
        if (fv == 0) begin fi = i; fv = 1; end
        err++;
      end
    end
    ps = (err == 0) ? 1 : 0;
  endtask

  // Full sweep: check the vector sequence, busy length, latency and results.
  task automatic run_sweep(input string tag, input logic [7:0] tt, input bit extra,
                           input int e_err, input int e_fi, input int e_fv, input int e_ps);
    int n, busy_cnt, lat, seq_ok;
    func_tt = tt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 1; busy_cnt = 0; lat = -1; seq_ok = 1;
    while (n <= 40) begin
      if (done) begin lat = n - 1; break; end
      if (busy) busy_cnt++;
      if (int'({a_out, b_out, c_out}) != (n - 1) / H) seq_ok = 0;
      start = (extra && (n == 5 || n == 20)) ? 1'b1 : 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({tag, ".latency"}, lat, 8 * H);
    check({tag, ".busy_cycles"}, busy_cnt, 8 * H);
    check({tag, ".vec_seq_ok"}, seq_ok, 1);
    check({tag, ".err_count"}, int'(err_count), e_err);
    check({tag, ".first_fail_idx"}, int'(ffi), e_fi);
    check({tag, ".first_fail_valid"}, int'(ffv), e_fv);
    check({tag, ".pass"}, int'(pass), e_ps);
    check({tag, ".abc_idle"}, int'({a_out, b_out, c_out, busy}), 0);
  endtask

  typedef struct {
    logic [7:0] tt;
    int err;
    int fi;
    int fv;
    int ps;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int e, fi, fv, ps, n;
    logic [7:0] rtt;
    exp_tt = 8'hE8;
    rst_n = 1'b0; start = 1'b0; start1 = 1'b0;
    func_tt = 8'hE8; func_tt1 = 8'hE9;

    // Expected values worked out by hand from the truth tables.
    tbl[0] = '{8'hE8, 0, 0, 0, 1};   // majority
    tbl[1] = '{8'h00, 4, 3, 1, 0};   // D stuck-at-0
    tbl[2] = '{8'h17, 8, 0, 1, 0};   // inverted D
    tbl[3] = '{8'hE9, 1, 0, 1, 0};   // only vector 0 wrong
    tbl[4] = '{8'h68, 1, 7, 1, 0};   // only vector 7 wrong
    tbl[5] = '{8'hE0, 1, 3, 1, 0};   // only vector 3 wrong

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.outputs", int'({a_out, b_out, c_out, busy, done, pass, ffv}), 0);
    check("rst.err_ffi", int'({err_count, ffi}), 0);
    check("rst.outputs_h1", int'({a1, b1, c1, busy1, done1, pass1, ffv1, err1, ffi1}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // HOLD_CYCLES=1: one cycle per vector
    start1 = 1'b1; @(negedge clk); start1 = 1'b0;
    n = 1;
    while (!done1 && n <= 20) begin @(negedge clk); n++; end
    check("h1.latency", n - 1, 8);
    check("h1.err_count", int'(err1), 1);
    check("h1.first_fail", int'({ffv1, ffi1}), 8);
    check("h1.pass", int'(pass1), 0);

    for (int i = 0; i < 6; i++)
      run_sweep($sformatf("tbl%0d", i), tbl[i].tt, 1'b0, tbl[i].err, tbl[i].fi, tbl[i].fv, tbl[i].ps);

    // Extra starts mid-sweep are ignored
    run_sweep("extra_start", 8'hE8, 1'b1, 0, 0, 0, 1);

    // Restart from DONE clears results on the accepting edge
    check("restart.pre_done_pass", int'({done, pass}), 3);
    func_tt = 8'h00;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("restart.done_pass", int'({done, pass}), 0);
    check("restart.busy_abc", int'({busy, a_out, b_out, c_out}), 8);
    check("restart.err_count", int'(err_count), 0);
    n = 0;
    while (!done && n < 100) begin @(negedge clk); n++; end
    check("restart.finished", int'(done), 1);
    check("restart.err_final", int'(err_count), 4);

    // Random truth tables against the model
    repeat (6) begin
      rtt = 8'($urandom);
      model(rtt, e, fi, fv, ps);
      run_sweep($sformatf("rand_%02h", rtt), rtt, 1'b0, e, fi, fv, ps);
    end

    // Reset mid-sweep at idx 3
    func_tt = 8'h17;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (12) @(negedge clk);
    check("midrst.pre_abc", int'({a_out, b_out, c_out}), 3);
    check("midrst.pre_err", int'(err_count), 3);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.async_outputs", int'({a_out, b_out, c_out, busy, done, pass, ffv}), 0);
    check("midrst.async_err", int'(err_count), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst.stay_idle", int'({busy, done, a_out, b_out, c_out}), 0);
    run_sweep("post_rst", 8'hE8, 1'b0, 0, 0, 0, 1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
